clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider. It generates a divided clock `clk_out` and a one-cycle `tick` enable from a single source clock `clk`. Divisors from 2 to 2^DIV_W−1 are supported, and odd divisors can produce an exact 50 % duty cycle. It sits beside the fixed dividers and feeds peripheral clocks and strobes whose rate software changes on the fly. Divisor changes and stop requests take effect only on a period boundary, so `clk_out` never glitches.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_neg_stage.sv | 23 ++
 rtl/clk_div_prog.sv | 179 +++++++++++++++++
 tb/tb_clk_div_prog.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and helpers for the programmable clock divider.
//   state_t  : divider run state (ST_STOP, ST_RUN)
//   MIN_DIV  : smallest divisor the counter can honour
//   hi_cnt() : number of source posedges per period for which p is high
// -----------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // Even N gives N/2, odd N gives (N-1)/2; both are a plain right shift.
  function automatic int unsigned hi_cnt(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_neg_stage.sv
// -----------------------------------------------------------------------------
// clk_div_neg_stage
// Negedge retiming flop that stretches the high phase of odd divisors by half a
// source cycle. Only instantiated when CLK_DIV_ODD50_EN is defined.
// Ports:
//   clk  in  source clock (falling edge used)
//   rst  in  asynchronous active-high reset
//   p    in  posedge-domain high-phase flop
//   n    out p delayed to the following negedge
// -----------------------------------------------------------------------------
module clk_div_neg_stage (
  input  logic clk,
  input  logic rst,
  input  logic p,
  output logic n
);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) n <= 1'b0;
    else     n <= p;
  end

endmodule

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
// Runtime-programmable integer clock divider producing a divided clock and a
// one-cycle tick on the last source cycle of each period. Divisor updates and
// stop requests are applied only on a period boundary so clk_out never glitches.
//
// Build option: define CLK_DIV_ODD50_EN to add the negedge stage that gives odd
// divisors an exact 50 % duty cycle. Without it odd N is high for (N-1)/2 cycles.
//
// Parameters:
//   DIV_W        divisor width in bits
//   DEFAULT_DIV  divisor loaded at reset (>= 2)
// Ports:
//   clk        in   source clock (both edges used when CLK_DIV_ODD50_EN)
//   rst        in   asynchronous active-high reset
//   en         in   run request, level-sensitive
//   div_valid  in   new divisor offered
//   div_data   in   new divisor value
//   div_ready  out  divisor can be accepted (no divisor pending)
//   div_err    out  one-cycle pulse: accepted divisor < 2 was discarded
//   running    out  block is in ST_RUN
//   clk_out    out  divided clock
//   tick       out  one-cycle pulse on the last source cycle of each period
// -----------------------------------------------------------------------------
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_valid,
  input  logic [DIV_W-1:0] div_data,
  output logic             div_ready,
  output logic             div_err,
  output logic             running,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] MIN_DIV_W = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_DIV   = DIV_W'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             p_q, p_d;
  logic             tick_q, tick_d;
  logic             div_err_q, div_err_d;

  logic             transfer;
  logic             last_cyc;
  logic             boundary;
  logic             commit;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] hi_div;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STOP;
      cnt_q      <= '0;
      cur_div_q  <= RST_DIV;
      pend_div_q <= RST_DIV;
      pend_vld_q <= 1'b0;
      p_q        <= 1'b0;
      tick_q     <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      p_q        <= p_d;
      tick_q     <= tick_d;
      div_err_q  <= div_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, handshake and waveform logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    p_d        = 1'b0;
    tick_d     = 1'b0;
    div_err_d  = 1'b0;

    transfer = div_valid && !pend_vld_q;
    last_cyc = (cnt_q == cur_div_q - ONE);
    boundary = (state_q == ST_STOP) || last_cyc;
    commit   = boundary && pend_vld_q;

    // The divisor that governs the period starting at this edge: a pending
    // value committed here takes effect immediately.
    div_eff = commit ? pend_div_q : cur_div_q;
    hi_div  = DIV_W'(hi_cnt(32'(div_eff)));

    // A transfer needs !pend_vld_q and a commit needs pend_vld_q, so the two
    // never collide in one cycle.
    if (commit) begin
      cur_div_d  = pend_div_q;
      pend_vld_d = 1'b0;
    end else if (transfer && (div_data >= MIN_DIV_W)) begin
      pend_div_d = div_data;
      pend_vld_d = 1'b1;
    end
    div_err_d = transfer && (div_data < MIN_DIV_W);

    case (state_q)
      ST_STOP: begin
        if (en) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (last_cyc) begin
          cnt_d = '0;
          if (!en) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase

    // Waveform flops look at the count the next cycle will carry.
    if (state_d == ST_RUN) begin
      p_d    = (cnt_d < hi_div);
      tick_d = (cnt_d == div_eff - ONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign div_ready = !pend_vld_q;
  assign div_err   = div_err_q;
  assign running   = (state_q == ST_RUN);
  assign tick      = tick_q;

`ifdef CLK_DIV_ODD50_EN
  logic n_q;

  clk_div_neg_stage u_neg_stage (
    .clk (clk),
    .rst (rst),
    .p   (p_q),
    .n   (n_q)
  );

  // n is low during the last cycle of every period (p is already low there),
  // so the odd/even select can change at a boundary without a glitch.
  assign clk_out = cur_div_q[0] ? (p_q | n_q) : p_q;
`else
  assign clk_out = p_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
// Directed self-checking bench for clk_div_prog (DIV_W = 8, DEFAULT_DIV = 3,
// 10 ns source clock). Expected duty depends on whether CLK_DIV_ODD50_EN is
// defined for the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clk_div_prog;

`ifdef CLK_DIV_ODD50_EN
  localparam bit ODD50 = 1'b1;
`else
  localparam bit ODD50 = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic       div_valid;
  logic [7:0] div_data;
  logic       div_ready;
  logic       div_err;
  logic       running;
  logic       clk_out;
  logic       tick;

  int checks   = 0;
  int failures = 0;

  clk_div_prog #(
    .DIV_W       (8),
    .DEFAULT_DIV (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_valid (div_valid),
    .div_data  (div_data),
    .div_ready (div_ready),
    .div_err   (div_err),
    .running   (running),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // High half-cycles expected in one period of divisor n.
  function automatic int exp_highs(input int n);
    if ((n % 2 == 0) || ODD50) return n;
    return n - 1;
  endfunction

  // Wait (bounded) for a tick, then sample clk_out at both clock phases over
  // the following full period. gap is the cycle index (1-based) of the tick
  // inside that period; contig is set when the period is one high run then lows.
  task automatic measure(input int n, output bit found, output int highs,
                         output int gap, output bit contig);
    bit s, prev, first;
    int rises;
    found = 1'b0; highs = 0; gap = 0; contig = 1'b0; rises = 0;
    prev = 1'b0; first = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (tick) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) return;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      s = clk_out;
      if (c == 0) first = s;
      else if (s && !prev) rises++;
      prev = s;
      if (s) highs++;
      if (tick && gap == 0) gap = c + 1;
      @(negedge clk); #1;
      s = clk_out;
      if (s && !prev) rises++;
      prev = s;
      if (s) highs++;
    end
    contig = first && (rises == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; div_valid = 1'b0; div_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL reset_div_ready: got %b want 1", div_ready); end
    checks++; if (div_err !== 1'b0) begin failures++; $display("FAIL reset_div_err: got %b want 0", div_err); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b want 0", tick); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL idle_running: got %b want 0", running); end
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL idle_clk_out: got %b want 0", clk_out); end
  endtask

  task automatic test_start();
    bit found, contig;
    int highs, gap;
    en = 1'b1;
    @(posedge clk); #1;
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running: got %b want 1", running); end
    checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL start_first_rise: got %b want 1", clk_out); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL start_tick: got %b want 0", tick); end
    measure(3, found, highs, gap, contig);
    checks++; if (!found || gap !== 3) begin failures++; $display("FAIL start_tick_period: found=%b gap=%0d want gap 3", found, gap); end
    checks++; if (!contig || highs !== exp_highs(3)) begin failures++; $display("FAIL start_duty: highs=%0d contig=%b want highs %0d", highs, contig, exp_highs(3)); end
  endtask

  task automatic test_even();
    bit found, contig;
    int highs, gap;
    div_valid = 1'b1; div_data = 8'd4;
    @(posedge clk); #1;
    div_valid = 1'b0;
    checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL even_ready_low: got %b want 0", div_ready); end
    measure(4, found, highs, gap, contig);
    checks++; if (!found || gap !== 4) begin failures++; $display("FAIL even_tick_period: found=%b gap=%0d want gap 4", found, gap); end
    checks++; if (!contig || highs !== 4) begin failures++; $display("FAIL even_duty: highs=%0d contig=%b want highs 4", highs, contig); end
    checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL even_ready_back: got %b want 1", div_ready); end
  endtask

  task automatic test_back_to_back();
    bit found, contig;
    int highs, gap, cyc;
    // Entered in the last cycle of an N=4 period; the next edge is a boundary.
    div_valid = 1'b1; div_data = 8'd6;
    @(posedge clk); #1;
    checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_low: got %b want 0", div_ready); end
    div_data = 8'd8;
    cyc = 0;
    while (!div_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 4) begin failures++; $display("FAIL b2b_ready_wait: got %0d cycles want 4", cyc); end
    @(posedge clk); #1;
    div_valid = 1'b0;
    checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_taken: got %b want 0", div_ready); end
    // Now in cycle 1 of the first N=6 period: four more edges to its tick.
    cyc = 0;
    while (!tick && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 4) begin failures++; $display("FAIL b2b_six_first: got %0d cycles to tick want 4", cyc); end
    measure(8, found, highs, gap, contig);
    checks++; if (!found || gap !== 8) begin failures++; $display("FAIL b2b_eight_period: found=%b gap=%0d want gap 8", found, gap); end
    checks++; if (!contig || highs !== 8) begin failures++; $display("FAIL b2b_eight_duty: highs=%0d contig=%b want highs 8", highs, contig); end
  endtask

  task automatic test_error();
    bit found, contig;
    int highs, gap;
    div_valid = 1'b1; div_data = 8'd1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    checks++; if (div_err !== 1'b1) begin failures++; $display("FAIL err_pulse: got %b want 1", div_err); end
    @(posedge clk); #1;
    checks++; if (div_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle: got %b want 0", div_err); end
    checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL err_ready: got %b want 1", div_ready); end
    measure(8, found, highs, gap, contig);
    checks++; if (!found || gap !== 8) begin failures++; $display("FAIL err_div_kept: found=%b gap=%0d want gap 8", found, gap); end
    checks++; if (!contig || highs !== 8) begin failures++; $display("FAIL err_duty_kept: highs=%0d contig=%b want highs 8", highs, contig); end
  endtask

  task automatic test_stop();
    bit found, contig;
    int highs, gap, edges, ticks, stray;
    div_valid = 1'b1; div_data = 8'd5;
    @(posedge clk); #1;
    div_valid = 1'b0;
    measure(5, found, highs, gap, contig);
    checks++; if (!found || gap !== 5) begin failures++; $display("FAIL stop_n5_period: found=%b gap=%0d want gap 5", found, gap); end
    checks++; if (!contig || highs !== exp_highs(5)) begin failures++; $display("FAIL stop_n5_duty: highs=%0d contig=%b want highs %0d", highs, contig, exp_highs(5)); end
    // Advance to cycle 1 of the next period, then drop the run request.
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b0;
    edges = 0; ticks = 0;
    while (running && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (tick) ticks++;
    end
    checks++; if (edges !== 4) begin failures++; $display("FAIL stop_latency: got %0d edges want 4", edges); end
    checks++; if (ticks !== 1) begin failures++; $display("FAIL stop_final_tick: got %0d ticks want 1", ticks); end
    stray = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (clk_out || tick) stray++;
      @(posedge clk); #1;
      if (clk_out || tick) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL stop_quiet: got %0d active samples want 0", stray); end
  endtask

  task automatic test_reset_mid();
    bit found, contig;
    int highs, gap, cyc;
    en = 1'b1;
    cyc = 0;
    while (!clk_out && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL rstmid_clk_high: got %b want 1", clk_out); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL rstmid_clk_out: got %b want 0", clk_out); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL rstmid_tick: got %b want 0", tick); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL rstmid_running: got %b want 0", running); end
    checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL rstmid_div_ready: got %b want 1", div_ready); end
    @(negedge clk); #1;
    rst = 1'b0;
    measure(3, found, highs, gap, contig);
    checks++; if (!found || gap !== 3) begin failures++; $display("FAIL rstmid_default_period: found=%b gap=%0d want gap 3", found, gap); end
    checks++; if (!contig || highs !== exp_highs(3)) begin failures++; $display("FAIL rstmid_default_duty: highs=%0d contig=%b want highs %0d", highs, contig, exp_highs(3)); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_even();
    test_back_to_back();
    test_error();
    test_stop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
